// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU between two
// valid/ready requesters. Operands are registered before the ALU and the
// result is registered after it. Each operation takes IDLE -> EXEC -> RESP.

module alu (
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic [3:0]  alu_op,
    output logic [31:0] result,
    output logic        zero,
    output logic        illegal
);

    // Decode the operation; undefined encodings fall back to addition and are flagged
    always_comb begin
        result  = op1 + op2;
        illegal = 1'b0;
        unique case (alu_op)
            4'b0000: result = op1 & op2;
            4'b0001: result = op1 | op2;
            4'b0010: result = op1 + op2;
            4'b0110: result = op1 - op2;
            4'b0111: result = {31'b0, ($signed(op1) < $signed(op2))};
            4'b1000: result = op1 >> op2[4:0];
            4'b1001: result = op1 << op2[4:0];
            4'b1010: result = 32'($signed(op1) >>> op2[4:0]);
            4'b1101: result = op1 ^ op2;
            default: illegal = 1'b1;
        endcase
        zero = (result == '0);
    end

endmodule

module alu_share_arbiter #(
    parameter int unsigned RESET_PRIORITY = 0,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [31:0]      req0_op1,
    input  logic [31:0]      req0_op2,
    input  logic [3:0]       req0_alu_op,
    input  logic [31:0]      req1_op1,
    input  logic [31:0]      req1_op2,
    input  logic [3:0]       req1_alu_op,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [31:0]      rsp_result,
    output logic             rsp_zero,
    output logic             rsp_illegal,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_q, state_d;
    logic             prio_q, prio_d;
    logic             owner_q, owner_d;
    logic [31:0]      op1_q, op1_d;
    logic [31:0]      op2_q, op2_d;
    logic [3:0]       aop_q, aop_d;
    logic [1:0]       rsp_valid_q, rsp_valid_d;
    logic [31:0]      result_q, result_d;
    logic             zero_q, zero_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             grant;
    logic             grant_vld;
    logic [31:0]      alu_result;
    logic             alu_zero;
    logic             alu_illegal;

    alu u_alu (
        .op1     (op1_q),
        .op2     (op2_q),
        .alu_op  (aop_q),
        .result  (alu_result),
        .zero    (alu_zero),
        .illegal (alu_illegal)
    );

    // Round-robin grant, only offered while idle
    always_comb begin
        grant     = 1'b0;
        grant_vld = 1'b0;
        if (state_q == IDLE) begin
            unique case (req_valid)
                2'b01:   begin grant = 1'b0;   grant_vld = 1'b1; end
                2'b10:   begin grant = 1'b1;   grant_vld = 1'b1; end
                2'b11:   begin grant = prio_q; grant_vld = 1'b1; end
                default: begin grant = 1'b0;   grant_vld = 1'b0; end
            endcase
        end
        req_ready = grant_vld ? (grant ? 2'b10 : 2'b01) : 2'b00;
    end

    // Next-state and register-update logic for the operation sequencer
    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        owner_d     = owner_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        aop_d       = aop_q;
        rsp_valid_d = rsp_valid_q;
        result_d    = result_q;
        zero_d      = zero_q;
        illegal_d   = illegal_q;
        cnt_d       = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    op1_d   = grant ? req1_op1    : req0_op1;
                    op2_d   = grant ? req1_op2    : req0_op2;
                    aop_d   = grant ? req1_alu_op : req0_alu_op;
                    owner_d = grant;
                    prio_d  = ~grant;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                result_d    = alu_result;
                zero_d      = alu_zero;
                illegal_d   = alu_illegal;
                rsp_valid_d = owner_q ? 2'b10 : 2'b01;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready[owner_q]) begin
                    rsp_valid_d = '0;
                    cnt_d       = cnt_q + CNT_W'(1);
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            prio_q      <= RESET_PRIORITY[0];
            owner_q     <= 1'b0;
            op1_q       <= '0;
            op2_q       <= '0;
            aop_q       <= '0;
            rsp_valid_q <= '0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            owner_q     <= owner_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            aop_q       <= aop_d;
            rsp_valid_q <= rsp_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            illegal_q   <= illegal_d;
            cnt_q       <= cnt_d;
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_result  = result_q;
    assign rsp_zero    = zero_q;
    assign rsp_illegal = illegal_q;
    assign busy        = (state_q != IDLE);
    assign op_count    = cnt_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed and swept checks for alu_share_arbiter.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [31:0] req0_op1 = '0, req0_op2 = '0, req1_op1 = '0, req1_op2 = '0;
    logic [3:0]  req0_alu_op = '0, req1_alu_op = '0;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready = '0;
    logic [31:0] rsp_result;
    logic        rsp_zero, rsp_illegal, busy;
    logic [15:0] op_count;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] exp_cnt  = '0;
    logic        mprio    = 1'b0;

    alu_share_arbiter #(.RESET_PRIORITY(0), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_op1(req0_op1), .req0_op2(req0_op2), .req0_alu_op(req0_alu_op),
        .req1_op1(req1_op1), .req1_op2(req1_op2), .req1_alu_op(req1_alu_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_illegal(rsp_illegal),
        .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void gold(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic ill);
        ill = 1'b0;
        case (op)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2:  r = a + b;
            4'd6:  r = a - b;
            4'd7:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd8:  r = a >> b[4:0];
            4'd9:  r = a << b[4:0];
            4'd10: r = $unsigned($signed(a) >>> b[4:0]);
            4'd13: r = a ^ b;
            default: begin r = a + b; ill = 1'b1; end
        endcase
    endfunction

    task automatic reset_dut();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_cnt = '0;
        mprio   = 1'b0;
    endtask

    // Called 1 time unit after a posedge with the DUT idle and requests driven.
    task automatic serve(input int g, input logic [31:0] er, input logic ez, input logic ei, input int stall);
        logic [1:0] own;
        logic [1:0] other;
        own   = (g == 1) ? 2'b10 : 2'b01;
        other = (g == 1) ? 2'b01 : 2'b10;
        @(negedge clk);
        chk("grant", req_ready, own);
        @(posedge clk);
        #1;
        req_valid = req_valid & ~own;
        mprio     = (g == 0);
        chk("exec_busy", busy, 1);
        chk("exec_rsp_valid", rsp_valid, 0);
        chk("exec_req_ready", req_ready, 0);
        @(posedge clk);
        #1;
        chk("rsp_valid", rsp_valid, own);
        chk("rsp_result", rsp_result, er);
        chk("rsp_zero", rsp_zero, ez);
        chk("rsp_illegal", rsp_illegal, ei);
        for (int i = 0; i < stall; i++) begin
            rsp_ready = other;
            @(posedge clk);
            #1;
            chk("stall_valid", rsp_valid, own);
            chk("stall_result", rsp_result, er);
            chk("stall_req_ready", req_ready, 0);
            chk("stall_busy", busy, 1);
        end
        rsp_ready = own;
        @(posedge clk);
        #1;
        rsp_ready = '0;
        exp_cnt++;
        chk("done_valid", rsp_valid, 0);
        chk("op_count", op_count, exp_cnt);
        chk("done_busy", busy, 0);
    endtask

    // Abort an accepted op with reset after `extra` further edges.
    task automatic abort_at(input int extra);
        req0_op1 = 32'hdead_beef; req0_op2 = 32'h1; req0_alu_op = 4'd2;
        req_valid = 2'b01;
        @(posedge clk);
        #1 req_valid = '0;
        repeat (extra) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_cnt = '0;
        mprio   = 1'b0;
        chk("abort_valid", rsp_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_count", op_count, 0);
        chk("abort_result", rsp_result, 0);
        rsp_ready = 2'b11;
        repeat (3) begin
            @(posedge clk);
            #1 chk("abort_stale", rsp_valid, 0);
        end
        rsp_ready = '0;
        // prio was flipped to 1 by the aborted accept; reset must restore 0
        req0_op1 = 32'd7; req0_op2 = 32'd3; req0_alu_op = 4'd6;
        req1_op1 = 32'd7; req1_op2 = 32'd3; req1_alu_op = 4'd13;
        req_valid = 2'b11;
        serve(0, 32'd4, 1'b0, 1'b0, 0);
        serve(1, 32'd4, 1'b0, 1'b0, 0);
    endtask

    logic [31:0] a1 [2];
    logic [31:0] a2 [2];
    logic [3:0]  ao [2];
    logic        pend [2];

    initial begin
        logic [31:0] er;
        logic        ei;
        int          g;

        reset_dut();
        chk("rst_valid", rsp_valid, 0);
        chk("rst_result", rsp_result, 0);
        chk("rst_zero", rsp_zero, 0);
        chk("rst_illegal", rsp_illegal, 0);
        chk("rst_count", op_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", req_ready, 0);

        // Single AND on port 0
        req0_op1 = 32'h1234_5678; req0_op2 = 32'h2456_fdec; req0_alu_op = 4'b0000;
        req_valid = 2'b01;
        serve(0, 32'h0014_5468, 1'b0, 1'b0, 0);

        // Both valid after reset: port 0 first, then port 1, then port 0 again
        reset_dut();
        req0_op1 = 32'h1234_5678; req0_op2 = 32'h2456_fdec; req0_alu_op = 4'b0010;
        req1_op1 = 32'd5;         req1_op2 = 32'd5;         req1_alu_op = 4'b0110;
        req_valid = 2'b11;
        serve(0, 32'h368B_5464, 1'b0, 1'b0, 0);
        serve(1, 32'h0, 1'b1, 1'b0, 0);
        req_valid = 2'b11;
        // Port 0 wins again; its response stalls 5 cycles with port 1 pending
        serve(0, 32'h368B_5464, 1'b0, 1'b0, 5);
        serve(1, 32'h0, 1'b1, 1'b0, 0);

        // Undefined encoding behaves as ADD and is flagged
        req0_op1 = 32'd1; req0_op2 = 32'hffff_ffff; req0_alu_op = 4'b0100;
        req_valid = 2'b01;
        serve(0, 32'h0, 1'b1, 1'b1, 0);

        // Reset during EXEC, then during RESP
        reset_dut();
        abort_at(0);
        abort_at(1);

        // Swept operations with round-robin tracking
        reset_dut();
        pend[0] = 1'b0; pend[1] = 1'b0;
        for (int it = 0; it < 200; it++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && ($urandom_range(0, 1) == 1)) begin
                    pend[p] = 1'b1;
                    a1[p] = $urandom; a2[p] = $urandom;
                    ao[p] = 4'($urandom_range(0, 15));
                end
            end
            if (!pend[0] && !pend[1]) begin
                g = $urandom_range(0, 1);
                pend[g] = 1'b1;
                a1[g] = $urandom; a2[g] = $urandom;
                ao[g] = 4'($urandom_range(0, 15));
            end
            req0_op1 = a1[0]; req0_op2 = a2[0]; req0_alu_op = ao[0];
            req1_op1 = a1[1]; req1_op2 = a2[1]; req1_alu_op = ao[1];
            req_valid = {pend[1], pend[0]};
            g = (pend[0] && pend[1]) ? int'(mprio) : (pend[1] ? 1 : 0);
            gold(ao[g], a1[g], a2[g], er, ei);
            serve(g, er, (er == 32'h0), ei, $urandom_range(0, 2));
            pend[g] = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
